// File: rtl/irq_pending_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module : irq_pending_ctrl_pkg
// Brief  : Shared constants and helpers for the interrupt pending controller.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package irq_pending_ctrl_pkg;

    localparam int NLINES = 4;
    localparam int IDW    = 2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    function automatic logic [NLINES-1:0] onehot(input logic [IDW-1:0] idx);
        logic [NLINES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_capture.sv
//------------------------------------------------------------------------------
// Module : irq_capture
// Brief  : Edge/level request capture with sticky pending and overflow bits.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module irq_capture
    import irq_pending_ctrl_pkg::*;
#(
    parameter int EDGE_MODE = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [NLINES-1:0] irq,
    input  logic              clr_en,
    input  logic [IDW-1:0]    clr_id,
    output logic [NLINES-1:0] pend,
    output logic [NLINES-1:0] ovf
);

    logic [NLINES-1:0] w_set;
    logic [NLINES-1:0] w_clr;
    logic [NLINES-1:0] r_pend;

    assign w_clr = clr_en ? onehot(clr_id) : '0;

    generate
        if (EDGE_MODE != 0) begin : g_edge
            logic [NLINES-1:0] r_irq_prev;
            logic [NLINES-1:0] r_ovf;

            always_ff @(posedge clk) begin
                if (!nrst) begin
                    r_irq_prev <= '0;
                    r_ovf      <= '0;
                end else begin
                    r_irq_prev <= irq;
                    // Issue clears overflow even if a fresh event lands the same cycle
                    r_ovf      <= (r_ovf | (w_set & r_pend & ~w_clr)) & ~w_clr;
                end
            end

            assign w_set = irq & ~r_irq_prev;
            assign ovf   = r_ovf;
        end else begin : g_level
            assign w_set = irq;
            assign ovf   = '0;
        end
    endgenerate

    // A new event coinciding with the issue of the same line is kept
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend | w_set) & ~(w_clr & ~w_set);
        end
    end

    assign pend = r_pend;

endmodule

`default_nettype wire

// File: rtl/irq_pending_ctrl.sv
//------------------------------------------------------------------------------
// Module : irq_pending_ctrl
// Brief  : Pending-request front end for a 4-input priority encoder with
//          single-outstanding valid/ready issue and ack-tracked service.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module irq_pending_ctrl
    import irq_pending_ctrl_pkg::*;
#(
    parameter int EDGE_MODE = 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [NLINES-1:0] irq,
    input  logic [NLINES-1:0] mask,
    output logic [NLINES-1:0] enc_i,
    input  logic [IDW-1:0]    enc_q,
    input  logic              enc_v,
    output logic              req_valid,
    output logic [IDW-1:0]    req_id,
    input  logic              req_ready,
    input  logic              ack,
    output logic              busy,
    output logic [NLINES-1:0] pend,
    output logic [NLINES-1:0] ovf
);

    logic [1:0]        r_state;
    logic              r_req_valid;
    logic [IDW-1:0]    r_req_id;
    logic              r_busy;
    logic              w_accept;
    logic [NLINES-1:0] w_pend;

    assign w_accept = r_req_valid & req_ready;

    irq_capture #(
        .EDGE_MODE (EDGE_MODE)
    ) u_capture (
        .clk    (clk),
        .nrst   (nrst),
        .irq    (irq),
        .clr_en (w_accept),
        .clr_id (r_req_id),
        .pend   (w_pend),
        .ovf    (ovf)
    );

    // Masked bits stay pending; only the encoder's view is gated
    assign enc_i = w_pend & mask;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state     <= ST_IDLE;
            r_req_valid <= 1'b0;
            r_req_id    <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enc_v) begin
                        r_req_id    <= enc_q;
                        r_req_valid <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_accept) begin
                        r_req_valid <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (ack) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_req_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_valid = r_req_valid;
    assign req_id    = r_req_id;
    assign busy      = r_busy;
    assign pend      = w_pend;

endmodule

`default_nettype wire

// File: tb/tb_irq_pending_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_irq_pending_ctrl
// Brief  : Directed self-checking bench for irq_pending_ctrl (edge and level).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_irq_pending_ctrl;

    logic       clk = 1'b0;
    logic       nrst;
    int         checks = 0;
    int         errors = 0;

    // Edge-mode instance
    logic [3:0] irq, mask, enc_i, pend, ovf;
    logic [1:0] enc_q, req_id;
    logic       enc_v, req_valid, req_ready, ack, busy;

    // Level-mode instance
    logic [3:0] irq_l, mask_l, enc_i_l, pend_l, ovf_l;
    logic [1:0] enc_q_l, req_id_l;
    logic       enc_v_l, req_valid_l, req_ready_l, ack_l, busy_l;

    always #5 clk = ~clk;

    irq_pending_ctrl #(.EDGE_MODE(1)) u_dut (
        .clk(clk), .nrst(nrst), .irq(irq), .mask(mask), .enc_i(enc_i),
        .enc_q(enc_q), .enc_v(enc_v), .req_valid(req_valid), .req_id(req_id),
        .req_ready(req_ready), .ack(ack), .busy(busy), .pend(pend), .ovf(ovf)
    );

    irq_pending_ctrl #(.EDGE_MODE(0)) u_dut_lvl (
        .clk(clk), .nrst(nrst), .irq(irq_l), .mask(mask_l), .enc_i(enc_i_l),
        .enc_q(enc_q_l), .enc_v(enc_v_l), .req_valid(req_valid_l), .req_id(req_id_l),
        .req_ready(req_ready_l), .ack(ack_l), .busy(busy_l), .pend(pend_l), .ovf(ovf_l)
    );

    // External priority encoder: lowest enabled index wins
    always_comb begin
        enc_v = |enc_i;
        enc_q = enc_i[0] ? 2'd0 : enc_i[1] ? 2'd1 : enc_i[2] ? 2'd2 : 2'd3;
        enc_v_l = |enc_i_l;
        enc_q_l = enc_i_l[0] ? 2'd0 : enc_i_l[1] ? 2'd1 : enc_i_l[2] ? 2'd2 : 2'd3;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0; irq = 4'b0100; mask = 4'hF; req_ready = 1'b0; ack = 1'b0;
        irq_l = 4'h0; mask_l = 4'hF; req_ready_l = 1'b0; ack_l = 1'b0;
        tick(); tick();
        checks++; if (pend !== 4'h0) begin errors++; $display("FAIL rst_pend: got %b exp 0000", pend); end
        checks++; if (ovf !== 4'h0) begin errors++; $display("FAIL rst_ovf: got %b exp 0000", ovf); end
        checks++; if ({req_valid, busy, req_id} !== 4'b0000) begin errors++; $display("FAIL rst_ctrl: valid=%b busy=%b id=%0d exp 0 0 0", req_valid, busy, req_id); end
        nrst = 1'b1;
        tick();
        checks++; if (pend !== 4'b0100) begin errors++; $display("FAIL rel_pend: got %b exp 0100", pend); end
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL rel_valid_early: got %b exp 0", req_valid); end
        tick();
        checks++; if ({req_valid, req_id, busy} !== {1'b1, 2'd2, 1'b0}) begin errors++; $display("FAIL rel_req: valid=%b id=%0d busy=%b exp 1 2 0", req_valid, req_id, busy); end
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        checks++; if ({req_valid, busy, pend} !== {1'b0, 1'b1, 4'b0000}) begin errors++; $display("FAIL rel_accept: valid=%b busy=%b pend=%b exp 0 1 0000", req_valid, busy, pend); end
        irq = 4'h0; ack = 1'b1; tick(); ack = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rel_ack: busy=%b exp 0", busy); end
    endtask

    task automatic test_back_to_back();
        irq = 4'b1010; tick();
        checks++; if (pend !== 4'b1010) begin errors++; $display("FAIL b2b_pend: got %b exp 1010", pend); end
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if ({req_valid, req_id} !== {1'b1, 2'd1}) begin errors++; $display("FAIL b2b_hold%0d: valid=%b id=%0d exp 1 1", i, req_valid, req_id); end
            tick();
        end
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        checks++; if ({pend, busy, req_valid} !== {4'b1000, 1'b1, 1'b0}) begin errors++; $display("FAIL b2b_accept: pend=%b busy=%b valid=%b exp 1000 1 0", pend, busy, req_valid); end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++; if ({busy, req_valid} !== 2'b00) begin errors++; $display("FAIL b2b_ack: busy=%b valid=%b exp 0 0", busy, req_valid); end
        tick();
        checks++; if ({req_valid, req_id} !== {1'b1, 2'd3}) begin errors++; $display("FAIL b2b_next: valid=%b id=%0d exp 1 3", req_valid, req_id); end
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        irq = 4'h0; ack = 1'b1; tick(); ack = 1'b0;
        checks++; if ({pend, busy} !== 5'b0) begin errors++; $display("FAIL b2b_done: pend=%b busy=%b exp 0000 0", pend, busy); end
    endtask

    task automatic test_mask();
        mask = 4'b1110; irq = 4'b0001; tick();
        checks++; if (pend !== 4'b0001) begin errors++; $display("FAIL mask_pend: got %b exp 0001", pend); end
        tick(); tick();
        checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL mask_blocked: valid=%b exp 0", req_valid); end
        checks++; if (enc_i !== 4'b0000) begin errors++; $display("FAIL mask_enc_i: got %b exp 0000", enc_i); end
        mask = 4'hF; tick();
        checks++; if ({req_valid, req_id} !== {1'b1, 2'd0}) begin errors++; $display("FAIL mask_open: valid=%b id=%0d exp 1 0", req_valid, req_id); end
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        irq = 4'h0; ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic test_ovf();
        irq = 4'b0100; tick();
        irq = 4'b0000; tick();
        checks++; if ({req_valid, req_id} !== {1'b1, 2'd2}) begin errors++; $display("FAIL ovf_req: valid=%b id=%0d exp 1 2", req_valid, req_id); end
        irq = 4'b0100; tick();
        checks++; if (ovf !== 4'b0100) begin errors++; $display("FAIL ovf_set: got %b exp 0100", ovf); end
        irq = 4'b0000; tick();
        irq = 4'b0100; req_ready = 1'b1; tick(); req_ready = 1'b0;
        checks++; if ({pend, ovf, busy} !== {4'b0100, 4'b0000, 1'b1}) begin errors++; $display("FAIL ovf_accept: pend=%b ovf=%b busy=%b exp 0100 0000 1", pend, ovf, busy); end
        irq = 4'b0000; ack = 1'b1; tick(); ack = 1'b0;
        tick();
        checks++; if ({req_valid, req_id} !== {1'b1, 2'd2}) begin errors++; $display("FAIL ovf_reissue: valid=%b id=%0d exp 1 2", req_valid, req_id); end
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        irq = 4'b0011; tick();
        tick();
        req_ready = 1'b1; tick(); req_ready = 1'b0;
        irq = 4'b0000; tick();
        irq = 4'b0001; tick();
        checks++; if ({pend, busy} !== {4'b0011, 1'b1}) begin errors++; $display("FAIL mid_setup: pend=%b busy=%b exp 0011 1", pend, busy); end
        nrst = 1'b0; #2; nrst = 1'b1;
        tick();
        checks++; if ({pend, busy} !== {4'b0011, 1'b1}) begin errors++; $display("FAIL mid_glitch: pend=%b busy=%b exp 0011 1", pend, busy); end
        nrst = 1'b0; tick(); nrst = 1'b1; irq = 4'b0000;
        checks++; if ({pend, ovf, busy, req_valid} !== 10'b0) begin errors++; $display("FAIL mid_reset: pend=%b ovf=%b busy=%b valid=%b exp 0000 0000 0 0", pend, ovf, busy, req_valid); end
        tick();
        checks++; if ({busy, req_valid, pend} !== 6'b0) begin errors++; $display("FAIL mid_idle: busy=%b valid=%b pend=%b exp 0 0 0000", busy, req_valid, pend); end
    endtask

    task automatic test_level();
        irq_l = 4'b0010; tick();
        checks++; if (pend_l !== 4'b0010) begin errors++; $display("FAIL lvl_pend: got %b exp 0010", pend_l); end
        tick();
        checks++; if ({req_valid_l, req_id_l} !== {1'b1, 2'd1}) begin errors++; $display("FAIL lvl_req: valid=%b id=%0d exp 1 1", req_valid_l, req_id_l); end
        req_ready_l = 1'b1; tick(); req_ready_l = 1'b0;
        checks++; if ({busy_l, pend_l, ovf_l} !== {1'b1, 4'b0010, 4'b0000}) begin errors++; $display("FAIL lvl_accept: busy=%b pend=%b ovf=%b exp 1 0010 0000", busy_l, pend_l, ovf_l); end
        ack_l = 1'b1; tick(); ack_l = 1'b0;
        checks++; if ({busy_l, req_valid_l} !== 2'b00) begin errors++; $display("FAIL lvl_ack: busy=%b valid=%b exp 0 0", busy_l, req_valid_l); end
        tick();
        checks++; if ({req_valid_l, req_id_l, ovf_l} !== {1'b1, 2'd1, 4'b0000}) begin errors++; $display("FAIL lvl_reissue: valid=%b id=%0d ovf=%b exp 1 1 0000", req_valid_l, req_id_l, ovf_l); end
        irq_l = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_mask();
        test_ovf();
        test_reset_mid();
        test_level();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
